// File: rtl/pong_pkg.sv
// ----------------------------------------------------------------------------
// pong_pkg : shared types, segment indices and the seven-segment hit test
// Rev 1.0  : initial release
// ----------------------------------------------------------------------------
`default_nettype none

package pong_pkg;

   typedef logic [11:0] rgb_t;
   typedef logic [6:0]  seg7_t;   // {g,f,e,d,c,b,a}
   typedef logic [3:0]  bcd_t;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   // True when cell-relative (dx,dy) lies in any lit segment; corners overlap.
   function automatic logic seg_hit(
      input logic [11:0] dx,
      input logic [11:0] dy,
      input logic [11:0] w,
      input logic [11:0] h,
      input logic [11:0] t,
      input logic [11:0] l,
      input seg7_t       segs
   );
      logic upper, lower, left, right;
      upper = dy < (t + t + l);
      lower = dy >= (t + l);
      left  = dx < t;
      right = dx >= (w - t);
      return (segs[SEG_A] && (dy < t))
          || (segs[SEG_G] && lower && upper)
          || (segs[SEG_D] && (dy >= (h - t)))
          || (segs[SEG_F] && left  && upper)
          || (segs[SEG_B] && right && upper)
          || (segs[SEG_E] && left  && lower)
          || (segs[SEG_C] && right && lower);
   endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// ----------------------------------------------------------------------------
// seg7_decode : BCD digit to seven-segment pattern, codes A-F all dark
// Rev 1.0     : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module seg7_decode
   import pong_pkg::*;
(
   input  bcd_t  digit,
   output seg7_t segs
);

   always_comb begin
      segs = 7'h00;
      case (digit)
         4'd0:    segs = 7'h3f;
         4'd1:    segs = 7'h06;
         4'd2:    segs = 7'h5b;
         4'd3:    segs = 7'h4f;
         4'd4:    segs = 7'h66;
         4'd5:    segs = 7'h6d;
         4'd6:    segs = 7'h7d;
         4'd7:    segs = 7'h07;
         4'd8:    segs = 7'h7f;
         4'd9:    segs = 7'h6f;
         default: segs = 7'h00;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/score_display.sv
// ----------------------------------------------------------------------------
// score_display : BCD score counter rendered as a two-digit 7-seg overlay.
//                 Post-point digit flashing is built when SCORE_FLASH_EN is set.
// Rev 1.0       : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module score_display
   import pong_pkg::*;
#(
   parameter int   XLOC         = 100,
   parameter int   YLOC         = 100,
   parameter int   SEG_LEN      = 16,
   parameter int   SEG_T        = 4,
   parameter int   GAP          = 8,
   parameter rgb_t COLOR        = 12'hfff,
   parameter int   MAX_SCORE    = 11,
   parameter int   FLASH_FRAMES = 8
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] x,
   input  logic [10:0] y,
   input  logic        frame_tick,
   input  logic        inc,
   input  logic        clear,
   output logic [11:0] rgb,
   output logic        win,
   output logic [7:0]  score
);

   localparam logic [11:0] c_t      = 12'(SEG_T);
   localparam logic [11:0] c_l      = 12'(SEG_LEN);
   localparam logic [11:0] c_w      = 12'(SEG_LEN + 2 * SEG_T);
   localparam logic [11:0] c_h      = 12'(2 * SEG_LEN + 3 * SEG_T);
   localparam logic [11:0] c_x_tens = 12'(XLOC);
   localparam logic [11:0] c_x_ones = 12'(XLOC + SEG_LEN + 2 * SEG_T + GAP);
   localparam logic [11:0] c_y      = 12'(YLOC);
   localparam logic [7:0]  c_max    = {4'(MAX_SCORE / 10), 4'(MAX_SCORE % 10)};

   logic [7:0] score_q, score_d;
   rgb_t       rgb_q, rgb_d;
   logic       inc_ok;
   logic       blink;

   assign inc_ok = inc && !clear && (score_q != c_max);

   always_comb begin
      score_d = score_q;
      if (clear) begin
         score_d = 8'h00;
      end else if (inc_ok) begin
         if (score_q[3:0] == 4'd9) begin
            score_d = {score_q[7:4] + 4'd1, 4'd0};
         end else begin
            score_d = {score_q[7:4], score_q[3:0] + 4'd1};
         end
      end
   end

`ifdef SCORE_FLASH_EN
   localparam logic [7:0] c_flash = 8'(FLASH_FRAMES);

   logic [7:0] flash_cnt_q, flash_cnt_d;
   logic       blink_q, blink_d;

   // A point reload outranks a simultaneous frame tick.
   always_comb begin
      flash_cnt_d = flash_cnt_q;
      blink_d     = blink_q;
      if (clear) begin
         flash_cnt_d = 8'd0;
         blink_d     = 1'b0;
      end else if (inc_ok) begin
         flash_cnt_d = c_flash;
         blink_d     = 1'b0;
      end else if (frame_tick && (flash_cnt_q != 8'd0)) begin
         flash_cnt_d = flash_cnt_q - 8'd1;
         blink_d     = (flash_cnt_q == 8'd1) ? 1'b0 : !blink_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flash_cnt_q <= 8'd0;
         blink_q     <= 1'b0;
      end else begin
         flash_cnt_q <= flash_cnt_d;
         blink_q     <= blink_d;
      end
   end

   assign blink = blink_q;
`else
   logic unused_frame_tick;
   assign unused_frame_tick = frame_tick;
   assign blink             = 1'b0;
`endif

   seg7_t tens_segs, ones_segs;

   seg7_decode u_dec_tens (.digit(score_q[7:4]), .segs(tens_segs));
   seg7_decode u_dec_ones (.digit(score_q[3:0]), .segs(ones_segs));

   logic [11:0] x_ext, y_ext, dx_tens, dx_ones, dy;
   logic        in_y, in_tens, in_ones, tens_hit, ones_hit;

   assign x_ext   = {1'b0, x};
   assign y_ext   = {1'b0, y};
   assign dx_tens = x_ext - c_x_tens;
   assign dx_ones = x_ext - c_x_ones;
   assign dy      = y_ext - c_y;

   assign in_y    = (y_ext >= c_y)      && (dy < c_h);
   assign in_tens = (x_ext >= c_x_tens) && (dx_tens < c_w);
   assign in_ones = (x_ext >= c_x_ones) && (dx_ones < c_w);

   // Leading zero of the tens digit is never drawn.
   assign tens_hit = in_y && in_tens && !blink && (score_q[7:4] != 4'd0)
                     && seg_hit(dx_tens, dy, c_w, c_h, c_t, c_l, tens_segs);
   assign ones_hit = in_y && in_ones && !blink
                     && seg_hit(dx_ones, dy, c_w, c_h, c_t, c_l, ones_segs);

   always_comb begin
      rgb_d = '0;
      if (tens_hit || ones_hit) begin
         rgb_d = COLOR;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         score_q <= 8'h00;
         rgb_q   <= '0;
      end else begin
         score_q <= score_d;
         rgb_q   <= rgb_d;
      end
   end

   assign rgb   = rgb_q;
   assign score = score_q;
   assign win   = (score_q == c_max);

endmodule

`default_nettype wire

// File: tb/tb_score_display.sv
// ----------------------------------------------------------------------------
// tb_score_display : directed scoreboard bench for score_display
// Rev 1.0          : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_score_display;
   import pong_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [10:0] x = 11'd0;
   logic [10:0] y = 11'd0;
   logic        frame_tick = 1'b0;
   logic        inc = 1'b0;
   logic        clear = 1'b0;
   logic [11:0] rgb;
   logic        win;
   logic [7:0]  score;

   score_display dut (
      .clk        (clk),
      .rst        (rst),
      .x          (x),
      .y          (y),
      .frame_tick (frame_tick),
      .inc        (inc),
      .clear      (clear),
      .rgb        (rgb),
      .win        (win),
      .score      (score)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [11:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   task automatic push(input string tag, input logic [11:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic check(input logic [11:0] obs);
      exp_t e;
      n_assert++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty: observed %h required an expected entry", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pixel(input int px, input int py, input logic [11:0] exp, input string tag);
      x = 11'(px);
      y = 11'(py);
      push(tag, exp);
      cyc();
      check(rgb);
   endtask

   task automatic chk_score(input logic [7:0] exp, input string tag);
      push(tag, {4'h0, exp});
      check({4'h0, score});
   endtask

   task automatic chk_win(input logic exp, input string tag);
      push(tag, {11'h0, exp});
      check({11'h0, win});
   endtask

   task automatic pulse_inc(input int n);
      for (int i = 0; i < n; i++) begin
         inc = 1'b1;
         cyc();
         inc = 1'b0;
      end
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      cyc();
      clear = 1'b0;
   endtask

   initial begin
      // reset state
      x = 11'd133;
      y = 11'd101;
      cyc();
      cyc();
      push("reset_rgb", 12'h000);
      check(rgb);
      chk_score(8'h00, "reset_score");
      chk_win(1'b0, "reset_win");
      rst = 1'b0;

      pixel(133, 101, 12'hfff, "zero_ones_a");
      pixel(101, 101, 12'h000, "zero_tens_blank");
      pixel(140, 121, 12'h000, "zero_g_off");

      // count through the ones wrap
      pulse_inc(9);
      chk_score(8'h09, "score_nine");
      pixel(140, 121, 12'hfff, "nine_g_on");
      pulse_inc(1);
      chk_score(8'h10, "score_ten");
      pixel(120, 105, 12'hfff, "ten_tens_b");
      pixel(140, 121, 12'h000, "ten_g_off");

      // saturation at the winning score
      pulse_inc(1);
      chk_score(8'h11, "score_max");
      chk_win(1'b1, "win_at_max");
      repeat (8) tick();
      pulse_inc(1);
      chk_score(8'h11, "sat_score_held");
      chk_win(1'b1, "sat_win_held");
      tick();
      pixel(153, 105, 12'hfff, "sat_no_flash");

      // clear outranks inc
      pulse_clear();
      pulse_inc(5);
      chk_score(8'h05, "score_five");
      clear = 1'b1;
      inc   = 1'b1;
      cyc();
      clear = 1'b0;
      inc   = 1'b0;
      chk_score(8'h00, "clear_over_inc");
      chk_win(1'b0, "clear_win_low");

`ifdef SCORE_FLASH_EN
      pulse_inc(1);
      pixel(153, 105, 12'hfff, "flash_before_tick");
      tick();
      pixel(153, 105, 12'h000, "flash_tick1_dark");
      tick();
      pixel(153, 105, 12'hfff, "flash_tick2_lit");
      repeat (5) tick();
      pixel(153, 105, 12'h000, "flash_tick7_dark");
      tick();
      pixel(153, 105, 12'hfff, "flash_tick8_lit");
      tick();
      pixel(153, 105, 12'hfff, "flash_tick9_lit");
      pulse_clear();
`endif

      // reset in the middle of a flash
      pulse_inc(7);
      chk_score(8'h07, "score_seven");
      x = 11'd153;
      y = 11'd105;
`ifdef SCORE_FLASH_EN
      tick();
`endif
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk_score(8'h00, "rst_score");
      push("rst_rgb", 12'h000);
      check(rgb);
      chk_win(1'b0, "rst_win");
      pixel(133, 101, 12'hfff, "post_rst_visible");

      if (sb.size() != 0) begin
         n_assert++;
         n_fail++;
         $error("FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
